// File: rtl/instr_reg_24.sv
// Instruction register for the SUBLEQ datapath: captures a 24-bit word on EN
// and holds it for the rest of the instruction cycle.
// The held word is also presented as the A, B and C operand fields.
module instr_reg_24 #(
  parameter int unsigned       WIDTH   = 24,
  parameter int unsigned       FIELD_W = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   instr_in,
  input  logic               EN,
  output logic [WIDTH-1:0]   instr_out,
  output logic [FIELD_W-1:0] field_a,
  output logic [FIELD_W-1:0] field_b,
  output logic [FIELD_W-1:0] field_c,
  output logic               loaded
);

  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] instr_d;
  logic             loaded_q;
  logic             loaded_d;

  // Reset has priority over a load strobe in the same cycle.
  always_comb begin
    instr_d  = instr_q;
    loaded_d = loaded_q;
    if (RST) begin
      instr_d  = RST_VAL;
      loaded_d = 1'b0;
    end else if (EN) begin
      instr_d  = instr_in;
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    instr_q  <= instr_d;
    loaded_q <= loaded_d;
  end

  assign instr_out = instr_q;
  assign loaded    = loaded_q;

  // A occupies the top field, C (branch target) the bottom one.
  assign field_a = instr_q[WIDTH-1 -: FIELD_W];
  assign field_b = instr_q[WIDTH-1-FIELD_W -: FIELD_W];
  assign field_c = instr_q[FIELD_W-1:0];

endmodule

// File: tb/tb_instr_reg_24.sv
// Self-checking bench for instr_reg_24: directed load/hold/reset scenarios,
// then randomized traffic compared each cycle against a behavioural model.
module tb_instr_reg_24;

  localparam int WIDTH   = 24;
  localparam int FIELD_W = 8;

  logic               CLK;
  logic               RST;
  logic [WIDTH-1:0]   instr_in;
  logic               EN;
  logic [WIDTH-1:0]   instr_out;
  logic [FIELD_W-1:0] field_a;
  logic [FIELD_W-1:0] field_b;
  logic [FIELD_W-1:0] field_c;
  logic               loaded;

  int errors = 0;
  int checks = 0;

  instr_reg_24 #(.WIDTH(WIDTH), .FIELD_W(FIELD_W), .RST_VAL(24'h0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .instr_in  (instr_in),
    .EN        (EN),
    .instr_out (instr_out),
    .field_a   (field_a),
    .field_b   (field_b),
    .field_c   (field_c),
    .loaded    (loaded)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Expected {loaded, word} after each edge, pushed at the edge, popped mid-cycle.
  logic [WIDTH:0] exp_q[$];
  int unsigned    model_word;
  bit             model_loaded;
  bit             model_known = 0;

  always @(posedge CLK) begin
    if (RST === 1'b1) begin
      model_word   = 0;
      model_loaded = 0;
      model_known  = 1;
    end else if (EN === 1'b1) begin
      model_word   = instr_in;
      model_loaded = 1;
    end
    if (model_known) exp_q.push_back({model_loaded, model_word[WIDTH-1:0]});
  end

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [WIDTH:0] e;
      int unsigned    w;
      e = exp_q.pop_front();
      w = e[WIDTH-1:0];
      check("sb_instr_out", 32'(instr_out), w);
      check("sb_field_a",   32'(field_a),   (w / 65536) % 256);
      check("sb_field_b",   32'(field_b),   (w / 256) % 256);
      check("sb_field_c",   32'(field_c),   w % 256);
      check("sb_loaded",    32'(loaded),    32'(e[WIDTH]));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic en, input logic [WIDTH-1:0] d);
    RST      = rst;
    EN       = en;
    instr_in = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; instr_in = 24'd1234;

    // Reset wins over EN with a live word on the bus.
    drive(1'b1, 1'b1, 24'd1234);
    check("rst_instr", 32'(instr_out), 32'h0);
    check("rst_loaded", 32'(loaded), 32'h0);

    // No load while EN is low.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 24'd1234);
    check("idle_hold", 32'(instr_out), 32'h0);
    check("idle_loaded", 32'(loaded), 32'h0);

    // Single load of 1234 = 0x0004D2.
    drive(1'b0, 1'b1, 24'd1234);
    check("load_instr", 32'(instr_out), 32'h0004D2);
    check("load_a", 32'(field_a), 32'h00);
    check("load_b", 32'(field_b), 32'h04);
    check("load_c", 32'(field_c), 32'hD2);
    check("load_loaded", 32'(loaded), 32'h1);

    // Bus changes with EN low are ignored.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 24'hABCDEF);
    check("hold_instr", 32'(instr_out), 32'h0004D2);

    // Back-to-back loads track the input one edge later.
    drive(1'b0, 1'b1, 24'h112233);
    check("b2b_first", 32'(instr_out), 32'h112233);
    drive(1'b0, 1'b1, 24'h445566);
    check("b2b_second", 32'(instr_out), 32'h445566);
    check("b2b_a", 32'(field_a), 32'h44);

    // Mid-instruction reset with EN also high.
    drive(1'b1, 1'b1, 24'hFFFFFF);
    check("rst_en_instr", 32'(instr_out), 32'h0);
    check("rst_en_loaded", 32'(loaded), 32'h0);

    // Randomized traffic with occasional resets and long EN-low stretches.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
            WIDTH'($urandom_range(0, 24'hFFFFFF)));
    end

    drive(1'b0, 1'b0, 24'h0);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
